// File: rtl/addsub_pkg.sv
// ============================================================================
// addsub_pkg : shared constants for the nibble-serial adder/subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int NIBBLE_W = 4;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/full_adder_1bit.sv
// ============================================================================
// full_adder_1bit : single-bit full adder cell
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/nibble_adder_cin.sv
// ============================================================================
// nibble_adder_cin : 4-bit ripple slice exposing carry into bit 3 and carry out
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_adder_cin
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                C3,
    output logic                Cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = Cin;

    generate
        for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
            full_adder_1bit u_fa (
                .a    (A[i]),
                .b    (B[i]),
                .cin  (w_c[i]),
                .s    (Sum[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    assign C3   = w_c[NIBBLE_W-1];
    assign Cout = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/addsub_16bit_serial.sv
// ============================================================================
// addsub_16bit_serial : nibble-serial A+B / A-B with overflow, start/busy/done
// Option macro: ADDSUB_SERIAL_SAT_EN (saturate Sum on overflow)
// Rev 1.0
// ============================================================================
`default_nettype none

module addsub_16bit_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]          state;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry_q;
    logic [CNT_W-1:0]    nib_cnt;
    logic [WIDTH-1:0]    sum_work;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_c3;
    logic                w_cout;
    logic [WIDTH-1:0]    w_sum_next;
    logic                w_last;
    logic                w_ovf;

    always_comb begin
        w_a_nib    = '0;
        w_b_nib    = '0;
        w_sum_next = sum_work;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nib_cnt == CNT_W'(k)) begin
                w_a_nib                        = a_q[k*NIBBLE_W +: NIBBLE_W];
                w_b_nib                        = b_q[k*NIBBLE_W +: NIBBLE_W];
                w_sum_next[k*NIBBLE_W +: NIBBLE_W] = w_nib_sum;
            end
        end
    end

    nibble_adder_cin u_slice (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (carry_q),
        .Sum  (w_nib_sum),
        .C3   (w_c3),
        .Cout (w_cout)
    );

    assign w_last = (nib_cnt == CNT_W'(NIBBLES - 1));
    assign w_ovf  = w_c3 ^ w_cout;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            nib_cnt  <= '0;
            sum_work <= '0;
            Sum      <= '0;
            Ovfl     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{sub}};
                        carry_q <= sub;
                        nib_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_work <= w_sum_next;
                    carry_q  <= w_cout;
                    nib_cnt  <= nib_cnt + CNT_W'(1);
                    if (w_last) begin
                        state <= S_DONE;
                        Ovfl  <= w_ovf;
`ifdef ADDSUB_SERIAL_SAT_EN
                        // On overflow both operand signs agree, so A's sign picks the rail
                        if (w_ovf)
                            Sum <= a_q[WIDTH-1] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
                        else
                            Sum <= w_sum_next;
`else
                        Sum <= w_sum_next;
`endif
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_addsub_16bit_serial.sv
// ============================================================================
// tb_addsub_16bit_serial : scoreboard bench with arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_addsub_16bit_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        sub = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Ovfl;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    addsub_16bit_serial #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Ovfl  (Ovfl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Reference: signed integer arithmetic, overflow when the true result leaves 16-bit range
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] r, output logic o);
        int sa, sb, f;
        sa = $signed(a);
        sb = $signed(b);
        f  = s ? (sa - sb) : (sa + sb);
        o  = (f > 32767) || (f < -32768);
        r  = f[15:0];
`ifdef ADDSUB_SERIAL_SAT_EN
        if (o) r = (f > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        model(a, b, s, e.sum, e.ovf);
        e.cyc = cyc + 4;
        exp_q.push_back(e);
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge after E5.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        push_exp(a, b, s);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", {16'h0, Sum}, {16'h0, e.sum});
                check("ovfl", {31'h0, Ovfl}, {31'h0, e.ovf});
                check("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_sum", {16'h0, Sum}, 32'd0);
        check("rst_ovfl", {31'h0, Ovfl}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(16'h1234, 16'h0FCD, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0);
        do_op(16'h0000, 16'h8000, 1'b1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1);

        // A second start during RUN must be ignored
        A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("busy_run", {31'h0, busy}, 32'd1);
        @(negedge clk);
        A = 16'h7FFF; B = 16'h7FFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_ignore", {31'h0, busy}, 32'd0);

        // Reset mid-operation, after E2
        do_op(16'h4321, 16'h1111, 1'b0);
        A = 16'h0F0F; B = 16'h00F0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'h0F0F, 16'h00F0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_sum", {16'h0, Sum}, 32'd0);
        check("abort_ovfl", {31'h0, Ovfl}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_op(16'hABCD, 16'h1234, 1'b1);

        // start held high: accepts land every 6 cycles with fresh operands
        start = 1'b1;
        for (int n = 0; n < 36; n++) begin
            A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
            ra = A; rb = B; rs = sub;
            @(posedge clk); #1;
            if (n % 6 == 0) push_exp(ra, rb, rs);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 8 == 0) ra = 16'h7FFF;
            if (n % 8 == 4) ra = 16'h8000;
            do_op(ra, rb, 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
